result_packer: RTL and testbench

- Stage directly downstream of the kernel array.
- Collects the 16-bit per-lane results once every lane reports valid.
- Packs lane pairs into 32-bit words, lane 2k in [15:0] and lane 2k+1 in [31:16].
- Streams the words into the host-read FIFO, honouring its almost_full back-pressure, then pulses done so the control FSM can return to idle.

---
 rtl/fpga_pkg.sv | 42 ++++
 rtl/lane_pair_mux.sv | 22 ++
 rtl/result_packer.sv | 123 ++++++++++++
 tb/tb_result_packer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_pkg.sv
// Shared definitions for the result packer slice: one-hot state encoding,
// lane/word width defaults and the word counter sizing helper.
// Optional build macro: RESULT_PACKER_CSUM_EN adds a CSUM state that
// emits an XOR trailer word after the data words.
package fpga_pkg;

    localparam int LANE_W_DEF    = 16;
    localparam int WORD_W        = 32;
    localparam int NUM_LANES_DEF = 512;

`ifdef RESULT_PACKER_CSUM_EN
    localparam int STATE_W = 5;
    localparam logic [4:0] ST_IDLE = 5'b00001;
    localparam logic [4:0] ST_WAIT = 5'b00010;
    localparam logic [4:0] ST_SEND = 5'b00100;
    localparam logic [4:0] ST_CSUM = 5'b01000;
    localparam logic [4:0] ST_DONE = 5'b10000;
`else
    localparam int STATE_W = 4;
    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_WAIT = 4'b0010;
    localparam logic [3:0] ST_SEND = 4'b0100;
    localparam logic [3:0] ST_DONE = 4'b1000;
`endif

    // Bit positions inside the one-hot vector used for output decode.
    localparam int S_IDLE_BIT = 0;
    localparam int S_DONE_BIT = STATE_W - 1;

    // Word counter width: enough to index NUM_LANES/2 pairs, never below 1.
    function automatic int cnt_width(input int num_lanes);
        int w;
        w = $clog2(num_lanes / 2);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/lane_pair_mux.sv
// Combinational select of one lane pair {lane[2k+1], lane[2k]} from the
// flattened lane bus. Because lane 2k sits in the lower half of the
// pair, the pair is simply a contiguous 2*LANE_W slice of the bus.
// Also used upstream as the mirror unpacker.
module lane_pair_mux
    import fpga_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int LANE_W    = LANE_W_DEF,
    parameter int IDX_W     = cnt_width(NUM_LANES)
) (
    input  logic [NUM_LANES*LANE_W-1:0] lane_data,
    input  logic [IDX_W-1:0]            pair_idx,
    output logic [2*LANE_W-1:0]         pair_data
);

    // Pick the 2*LANE_W slice that holds pair number pair_idx.
    always_comb begin
        pair_data = lane_data[int'(pair_idx) * (2 * LANE_W) +: (2 * LANE_W)];
    end

endmodule

// File: rtl/result_packer.sv
// Result packer: waits for all kernel lanes to be valid, then streams
// lane pairs as packed words into the host-read FIFO under almost_full
// back-pressure and pulses done. Lanes are not snapshotted; the upstream
// array holds lane_data stable until done.
// Optional build macro: RESULT_PACKER_CSUM_EN appends an XOR trailer word.
module result_packer
    import fpga_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int LANE_W    = LANE_W_DEF
) (
    input  logic                        bus_clk,
    input  logic                        srst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NUM_LANES*LANE_W-1:0] lane_data,
    input  logic [NUM_LANES-1:0]        lane_valid,
    input  logic                        fifo_almost_full,
    output logic                        fifo_wr_en,
    output logic [2*LANE_W-1:0]         fifo_din,
    output logic                        busy,
    output logic                        done
);

    localparam int PAIR_W    = 2 * LANE_W;
    localparam int NUM_WORDS = NUM_LANES / 2;
    localparam int CNT_W     = cnt_width(NUM_LANES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    logic [STATE_W-1:0] state_r;
    logic [CNT_W-1:0]   word_cnt_r;
    logic               wr_en_r;
    logic [PAIR_W-1:0]  din_r;
    logic [PAIR_W-1:0]  pair_s;
    logic               all_valid_s;
`ifdef RESULT_PACKER_CSUM_EN
    logic [PAIR_W-1:0]  csum_r;
`endif

    assign all_valid_s = &lane_valid;

    lane_pair_mux #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W),
        .IDX_W     (CNT_W)
    ) u_pair_mux (
        .lane_data (lane_data),
        .pair_idx  (word_cnt_r),
        .pair_data (pair_s)
    );

    // Sequencer, word counter and registered FIFO write path; abort is a
    // full synchronous clear, same as srst, and overrides everything else.
    always_ff @(posedge bus_clk) begin
        if (srst || abort) begin
            state_r    <= ST_IDLE;
            word_cnt_r <= '0;
            wr_en_r    <= 1'b0;
            din_r      <= '0;
`ifdef RESULT_PACKER_CSUM_EN
            csum_r     <= '0;
`endif
        end else begin
            wr_en_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    word_cnt_r <= '0;
`ifdef RESULT_PACKER_CSUM_EN
                    csum_r     <= '0;
`endif
                    if (start) begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (all_valid_s) begin
                        state_r <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!fifo_almost_full) begin
                        wr_en_r <= 1'b1;
                        din_r   <= pair_s;
`ifdef RESULT_PACKER_CSUM_EN
                        csum_r  <= csum_r ^ pair_s;
`endif
                        // The counter stops at the last index so it never wraps.
                        if (word_cnt_r == LAST_IDX) begin
`ifdef RESULT_PACKER_CSUM_EN
                            state_r <= ST_CSUM;
`else
                            state_r <= ST_DONE;
`endif
                        end else begin
                            word_cnt_r <= word_cnt_r + CNT_W'(1);
                        end
                    end
                end
`ifdef RESULT_PACKER_CSUM_EN
                ST_CSUM: begin
                    if (!fifo_almost_full) begin
                        wr_en_r <= 1'b1;
                        din_r   <= csum_r;
                        state_r <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_wr_en = wr_en_r;
    assign fifo_din   = din_r;
    assign busy       = ~state_r[S_IDLE_BIT];
    assign done       = state_r[S_DONE_BIT];

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer with NUM_LANES=8, LANE_W=16.
// Expected words come from a queue-based model of the packing rule.
module tb_result_packer;

    localparam int NL = 8;
    localparam int LW = 16;
    localparam int NW_DATA = NL / 2;
`ifdef RESULT_PACKER_CSUM_EN
    localparam int NW = NW_DATA + 1;
`else
    localparam int NW = NW_DATA;
`endif
    localparam logic [31:0] BASIC_W [4] = '{32'h10011000, 32'h10031002, 32'h10051004, 32'h10071006};

    logic              bus_clk = 1'b0;
    logic              srst;
    logic              start;
    logic              abort;
    logic              af;
    logic [NL*LW-1:0]  lane_data;
    logic [NL-1:0]     lane_valid;
    logic              fifo_wr_en;
    logic [2*LW-1:0]   fifo_din;
    logic              busy;
    logic              done;

    int total = 0;
    int bad = 0;

    logic [LW-1:0] lane_arr [NL];
    logic [31:0]   exp_q[$];
    logic [31:0]   got_q[$];
    int            wr_cyc_q[$];
    int            done_cyc_q[$];
    int            busy_low_cyc;
    int            af_viol;

    always #5 bus_clk = ~bus_clk;

    result_packer #(.NUM_LANES(NL), .LANE_W(LW)) dut (
        .bus_clk          (bus_clk),
        .srst             (srst),
        .start            (start),
        .abort            (abort),
        .lane_data        (lane_data),
        .lane_valid       (lane_valid),
        .fifo_almost_full (af),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_din         (fifo_din),
        .busy             (busy),
        .done             (done)
    );

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic apply_lanes();
        for (int i = 0; i < NL; i++) lane_data[i*LW +: LW] = lane_arr[i];
    endtask

    task automatic seq_lanes();
        for (int i = 0; i < NL; i++) lane_arr[i] = 16'h1000 + 16'(i);
        apply_lanes();
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < NL; i++) lane_arr[i] = 16'($urandom);
        apply_lanes();
    endtask

    // Model: word k = {lane 2k+1, lane 2k}; optional trailer = XOR of data words.
    function automatic void build_exp();
        logic [31:0] x;
        logic [31:0] w;
        exp_q.delete();
        x = 32'h0;
        for (int k = 0; k < NW_DATA; k++) begin
            w = {lane_arr[2*k+1], lane_arr[2*k]};
            exp_q.push_back(w);
            x = x ^ w;
        end
`ifdef RESULT_PACKER_CSUM_EN
        exp_q.push_back(x);
`endif
    endfunction

    // Runs ncyc clock cycles, driving back-pressure/start and recording outputs.
    task automatic observe(input int ncyc, input int stall_after, input int stall_len,
                           input int start_at, input bit rand_af, input bit drop_valid);
        int stalled;
        bit af_prev;
        stalled = 0;
        got_q.delete(); wr_cyc_q.delete(); done_cyc_q.delete();
        busy_low_cyc = -1;
        af_viol = 0;
        for (int i = 1; i <= ncyc; i++) begin
            if (rand_af) af = ($urandom_range(0, 2) == 0);
            else if (got_q.size() == stall_after && stalled < stall_len) begin
                af = 1'b1;
                stalled++;
            end else af = 1'b0;
            start = (i == start_at);
            if (drop_valid && got_q.size() > 0) lane_valid = NL'($urandom);
            af_prev = af;
            tick();
            if (fifo_wr_en) begin
                got_q.push_back(fifo_din);
                wr_cyc_q.push_back(i);
                if (af_prev) af_viol++;
            end
            if (done) done_cyc_q.push_back(i);
            if (!busy && busy_low_cyc < 0 && done_cyc_q.size() > 0) busy_low_cyc = i;
        end
        af = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        srst = 1'b1; start = 1'b0; abort = 1'b0; af = 1'b0;
        lane_valid = '0; lane_data = '0;
        tick(); tick();
        srst = 1'b0;
        total++;
        if ({fifo_wr_en, fifo_din, busy, done} !== 35'h0) begin
            bad++;
            $display("FAIL reset: got wr=%b din=%h busy=%b done=%b want all 0", fifo_wr_en, fifo_din, busy, done);
        end
    endtask

    task automatic test_basic();
        seq_lanes(); lane_valid = '1; build_exp();
        start = 1'b1; tick(); start = 1'b0;
        observe(NW + 8, -1, 0, 0, 1'b0, 1'b0);
        total++;
        if (got_q.size() !== NW) begin bad++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), NW); end
        for (int j = 0; j < NW && j < got_q.size(); j++) begin
            total++;
            if (j < 4 && got_q[j] !== BASIC_W[j]) begin
                bad++; $display("FAIL basic_word%0d: got %h want %h", j, got_q[j], BASIC_W[j]);
            end else if (got_q[j] !== exp_q[j]) begin
                bad++; $display("FAIL basic_word%0d: got %h want %h", j, got_q[j], exp_q[j]);
            end
            total++;
            if (wr_cyc_q[j] !== 2 + j) begin bad++; $display("FAIL basic_cycle%0d: got %0d want %0d", j, wr_cyc_q[j], 2 + j); end
        end
        total++;
        if (done_cyc_q.size() !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_cyc_q.size()); end
        else begin
            total++;
            if (done_cyc_q[0] !== 1 + NW) begin bad++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc_q[0], 1 + NW); end
            total++;
            if (busy_low_cyc !== done_cyc_q[0] + 1) begin bad++; $display("FAIL basic_busy_drop: got %0d want %0d", busy_low_cyc, done_cyc_q[0] + 1); end
        end
    endtask

    task automatic test_valid_late();
        int nwr;
        seq_lanes(); lane_valid = '1; lane_valid[5] = 1'b0; build_exp();
        start = 1'b1; tick(); start = 1'b0;
        nwr = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (fifo_wr_en) nwr++; end
        total++;
        if (nwr !== 0) begin bad++; $display("FAIL late_early_write: got %0d want 0", nwr); end
        lane_valid[5] = 1'b1;
        observe(NW + 8, -1, 0, 0, 1'b0, 1'b0);
        total++;
        if (got_q.size() !== NW) begin bad++; $display("FAIL late_count: got %0d want %0d", got_q.size(), NW); end
        else begin
            total++;
            if (wr_cyc_q[0] !== 2) begin bad++; $display("FAIL late_latency: got %0d want 2", wr_cyc_q[0]); end
            for (int j = 0; j < NW; j++) begin
                total++;
                if (got_q[j] !== exp_q[j]) begin bad++; $display("FAIL late_word%0d: got %h want %h", j, got_q[j], exp_q[j]); end
            end
        end
    endtask

    task automatic test_backpressure();
        seq_lanes(); lane_valid = '1; build_exp();
        start = 1'b1; tick(); start = 1'b0;
        observe(NW + 12, 2, 3, 0, 1'b0, 1'b0);
        total++;
        if (af_viol !== 0) begin bad++; $display("FAIL bp_write_in_stall: got %0d want 0", af_viol); end
        total++;
        if (got_q.size() !== NW) begin bad++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), NW); end
        else begin
            for (int j = 0; j < NW; j++) begin
                total++;
                if (got_q[j] !== exp_q[j]) begin bad++; $display("FAIL bp_word%0d: got %h want %h", j, got_q[j], exp_q[j]); end
            end
            total++;
            if (wr_cyc_q[2] - wr_cyc_q[1] !== 4) begin bad++; $display("FAIL bp_gap: got %0d want 4", wr_cyc_q[2] - wr_cyc_q[1]); end
            total++;
            if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== wr_cyc_q[NW-1]) begin
                bad++; $display("FAIL bp_done: got %0d pulses want 1 at last write", done_cyc_q.size());
            end
        end
    endtask

    task automatic test_abort();
        int nwr;
        int late;
        rand_lanes(); lane_valid = '1;
        start = 1'b1; tick(); start = 1'b0;
        nwr = 0;
        for (int i = 0; i < 20 && nwr < 2; i++) begin tick(); if (fifo_wr_en) nwr++; end
        total++;
        if (nwr !== 2) begin bad++; $display("FAIL abort_timeout: got %0d writes want 2", nwr); end
        abort = 1'b1; tick(); abort = 1'b0;
        total++;
        if ({fifo_wr_en, busy, done} !== 3'b000) begin
            bad++; $display("FAIL abort_clear: got wr=%b busy=%b done=%b want 000", fifo_wr_en, busy, done);
        end
        late = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (done || fifo_wr_en || busy) late++; end
        total++;
        if (late !== 0) begin bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", late); end
        seq_lanes(); build_exp();
        start = 1'b1; tick(); start = 1'b0;
        observe(NW + 8, -1, 0, 0, 1'b0, 1'b0);
        total++;
        if (got_q.size() !== NW) begin bad++; $display("FAIL abort_restart_count: got %0d want %0d", got_q.size(), NW); end
        else begin
            total++;
            if (got_q[0] !== 32'h10011000) begin bad++; $display("FAIL abort_restart_first: got %h want 10011000", got_q[0]); end
            for (int j = 1; j < NW; j++) begin
                total++;
                if (got_q[j] !== exp_q[j]) begin bad++; $display("FAIL abort_restart_word%0d: got %h want %h", j, got_q[j], exp_q[j]); end
            end
        end
    endtask

    task automatic test_start_in_send();
        int nwr;
        seq_lanes(); lane_valid = '1; build_exp();
        start = 1'b1; tick(); start = 1'b0;
        observe(NW + 12, -1, 0, 3, 1'b0, 1'b0);
        total++;
        if (got_q.size() !== NW || done_cyc_q.size() !== 1) begin
            bad++; $display("FAIL start_in_send: got %0d writes %0d dones want %0d and 1", got_q.size(), done_cyc_q.size(), NW);
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL start_in_send_busy: got %b want 0", busy); end
        // srst in the middle of SEND
        start = 1'b1; tick(); start = 1'b0;
        nwr = 0;
        for (int i = 0; i < 20 && nwr < 1; i++) begin tick(); if (fifo_wr_en) nwr++; end
        total++;
        if (nwr !== 1) begin bad++; $display("FAIL srst_timeout: got %0d writes want 1", nwr); end
        srst = 1'b1; tick(); srst = 1'b0;
        total++;
        if ({fifo_wr_en, fifo_din, busy, done} !== 35'h0) begin
            bad++; $display("FAIL srst_mid_send: got wr=%b din=%h busy=%b done=%b want all 0", fifo_wr_en, fifo_din, busy, done);
        end
    endtask

    task automatic test_start_abort_same();
        int act;
        lane_valid = '1;
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        act = 0;
        if (busy) act++;
        for (int i = 0; i < 4; i++) begin tick(); if (busy || fifo_wr_en) act++; end
        total++;
        if (act !== 0) begin bad++; $display("FAIL start_abort: got %0d active cycles want 0", act); end
    endtask

    task automatic test_random();
        int d;
        for (int it = 0; it < 6; it++) begin
            rand_lanes(); build_exp();
            lane_valid = '1;
            lane_valid[$urandom_range(0, NL-1)] = 1'b0;
            start = 1'b1; tick(); start = 1'b0;
            d = $urandom_range(0, 4);
            for (int i = 0; i < d; i++) tick();
            lane_valid = '1;
            observe(60, -1, 0, 0, 1'b1, 1'b1);
            total++;
            if (got_q.size() !== NW) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d", it, got_q.size(), NW); end
            else begin
                for (int j = 0; j < NW; j++) begin
                    total++;
                    if (got_q[j] !== exp_q[j]) begin bad++; $display("FAIL rand%0d_word%0d: got %h want %h", it, j, got_q[j], exp_q[j]); end
                end
                total++;
                if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== wr_cyc_q[NW-1]) begin
                    bad++; $display("FAIL rand%0d_done: got %0d pulses want 1 at last write", it, done_cyc_q.size());
                end
            end
            total++;
            if (af_viol !== 0) begin bad++; $display("FAIL rand%0d_af: got %0d writes under almost_full want 0", it, af_viol); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_valid_late();
        test_backpressure();
        test_abort();
        test_start_in_send();
        test_start_abort_same();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
